// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and constants for the fetch aligner
package ibex_pkg;

    typedef enum logic [1:0] {
        ALIGN_ALIGNED,
        ALIGN_SKIP,
        ALIGN_HALF,
        ALIGN_ERR
    } fetch_align_e;

    localparam logic [31:0] PC_INC_C = 32'd2;
    localparam logic [31:0] PC_INC_I = 32'd4;

endpackage

// File: rtl/ibex_fetch_aligner.sv
// rtl/ibex_fetch_aligner.sv - splits word-aligned fetch words into single RISC-V instructions
module ibex_fetch_aligner
    import ibex_pkg::*;
#(
    parameter logic [31:0] ResetPc = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_compressed_o,
    output logic        out_err_o
);

    localparam fetch_align_e RESET_ST = ResetPc[1] ? ALIGN_SKIP : ALIGN_ALIGNED;

    fetch_align_e st;
    logic [15:0]  hold;
    logic [31:0]  pc;
    // A bus error seen while skipping a low half has no instruction to report yet;
    // it is reported at the redirect PC once the output register is free.
    logic         err_pend;

    logic adv;
    logic hold_c;
    logic accept;
    logic low_c;

    // Handshake and ready derivation; ready never looks at fetch_valid_i.
    always_comb begin
        adv           = !out_valid_o | out_ready_i;
        hold_c        = hold[1:0] != 2'b11;
        low_c         = fetch_rdata_i[1:0] != 2'b11;
        fetch_ready_o = flush_i | (st == ALIGN_SKIP) | (st == ALIGN_ERR)
                      | (adv & !((st == ALIGN_HALF) & hold_c));
        accept        = fetch_valid_i & fetch_ready_o;
    end

    // Alignment FSM with registered instruction output and PC tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st               <= RESET_ST;
            hold             <= 16'h0;
            pc               <= ResetPc;
            err_pend         <= 1'b0;
            out_valid_o      <= 1'b0;
            out_instr_o      <= 32'h0;
            out_pc_o         <= 32'h0;
            out_compressed_o <= 1'b0;
            out_err_o        <= 1'b0;
        end else if (flush_i) begin
            st          <= flush_pc_i[1] ? ALIGN_SKIP : ALIGN_ALIGNED;
            hold        <= 16'h0;
            pc          <= {flush_pc_i[31:1], 1'b0};
            err_pend    <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            // Output drains by default; an emission below overrides this.
            if (adv) begin
                out_valid_o <= 1'b0;
            end
            case (st)
                ALIGN_ALIGNED: begin
                    if (accept) begin
                        out_valid_o <= 1'b1;
                        out_pc_o    <= pc;
                        if (fetch_err_i) begin
                            out_instr_o      <= 32'h0;
                            out_compressed_o <= 1'b0;
                            out_err_o        <= 1'b1;
                            pc               <= pc + PC_INC_I;
                            st               <= ALIGN_ERR;
                        end else if (low_c) begin
                            out_instr_o      <= {16'h0, fetch_rdata_i[15:0]};
                            out_compressed_o <= 1'b1;
                            out_err_o        <= 1'b0;
                            pc               <= pc + PC_INC_C;
                            hold             <= fetch_rdata_i[31:16];
                            st               <= ALIGN_HALF;
                        end else begin
                            out_instr_o      <= fetch_rdata_i;
                            out_compressed_o <= 1'b0;
                            out_err_o        <= 1'b0;
                            pc               <= pc + PC_INC_I;
                        end
                    end
                end
                ALIGN_HALF: begin
                    if (hold_c) begin
                        // Second compressed half needs no new word.
                        if (adv) begin
                            out_valid_o      <= 1'b1;
                            out_pc_o         <= pc;
                            out_instr_o      <= {16'h0, hold};
                            out_compressed_o <= 1'b1;
                            out_err_o        <= 1'b0;
                            pc               <= pc + PC_INC_C;
                            st               <= ALIGN_ALIGNED;
                        end
                    end else if (accept) begin
                        out_valid_o <= 1'b1;
                        out_pc_o    <= pc;
                        pc          <= pc + PC_INC_I;
                        if (fetch_err_i) begin
                            out_instr_o      <= 32'h0;
                            out_compressed_o <= 1'b0;
                            out_err_o        <= 1'b1;
                            st               <= ALIGN_ERR;
                        end else begin
                            out_instr_o      <= {fetch_rdata_i[15:0], hold};
                            out_compressed_o <= 1'b0;
                            out_err_o        <= 1'b0;
                            hold             <= fetch_rdata_i[31:16];
                        end
                    end
                end
                ALIGN_SKIP: begin
                    if (accept) begin
                        if (fetch_err_i) begin
                            err_pend <= 1'b1;
                            st       <= ALIGN_ERR;
                        end else begin
                            hold <= fetch_rdata_i[31:16];
                            st   <= ALIGN_HALF;
                        end
                    end
                end
                default: begin
                    // ALIGN_ERR: words are swallowed until a flush.
                    if (err_pend && adv) begin
                        out_valid_o      <= 1'b1;
                        out_pc_o         <= pc;
                        out_instr_o      <= 32'h0;
                        out_compressed_o <= 1'b0;
                        out_err_o        <= 1'b1;
                        pc               <= pc + PC_INC_I;
                        err_pend         <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_fetch_aligner.sv
// tb/tb_ibex_fetch_aligner.sv - scoreboard bench for ibex_fetch_aligner
module tb_ibex_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_compressed;
    logic        out_err;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    ibex_fetch_aligner #(.ResetPc(32'h0000_0080)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .fetch_valid_i    (fetch_valid),
        .fetch_ready_o    (fetch_ready),
        .fetch_rdata_i    (fetch_rdata),
        .fetch_err_i      (fetch_err),
        .flush_i          (flush),
        .flush_pc_i       (flush_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_instr_o      (out_instr),
        .out_pc_o         (out_pc),
        .out_compressed_o (out_compressed),
        .out_err_o        (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted output is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got instr %h pc %h with empty scoreboard", out_instr, out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_pc", out_pc, e.pc);
                check("out_compressed", {31'h0, out_compressed}, {31'h0, e.comp});
                check("out_err", {31'h0, out_err}, {31'h0, e.err});
            end
        end
    end

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic comp, input logic err);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.comp  = comp;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Offer one word and return #1 after the edge on which it was accepted.
    task automatic send(input logic [31:0] data, input logic err);
        int n;
        fetch_valid = 1'b1;
        fetch_rdata = data;
        fetch_err   = err;
        n = 0;
        forever begin
            @(negedge clk);
            if (fetch_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: word %h not accepted after %0d cycles", data, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        fetch_err   = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush    = 1'b1;
        flush_pc = target;
        @(posedge clk);
        #1;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_rdata = 32'h0;
        fetch_err   = 1'b0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        out_ready   = 1'b1;
        idle(2);
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_err", {31'h0, out_err}, 32'h0);
        check("rst_out_compressed", {31'h0, out_compressed}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_fetch_ready", {31'h0, fetch_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Aligned word after reset, then continue at 0x84.
        push(32'h0000_0013, 32'h80, 1'b0, 1'b0);
        send(32'h0000_0013, 1'b0);
        push(32'h0010_0093, 32'h84, 1'b0, 1'b0);
        send(32'h0010_0093, 1'b0);
        idle(3);

        // Two compressed in one word; no fetch during the second half.
        do_flush(32'h80);
        push(32'h0000_4501, 32'h80, 1'b1, 1'b0);
        push(32'h0000_4505, 32'h82, 1'b1, 1'b0);
        send(32'h4505_4501, 1'b0);
        @(negedge clk);
        check("second_half_fetch_ready", {31'h0, fetch_ready}, 32'h0);
        idle(3);

        // Straddling 32-bit instruction.
        do_flush(32'h80);
        push(32'h0000_4501, 32'h80, 1'b1, 1'b0);
        push(32'h0000_0013, 32'h82, 1'b0, 1'b0);
        push(32'h0000_4505, 32'h86, 1'b1, 1'b0);
        send(32'h0013_4501, 1'b0);
        send(32'h4505_0000, 1'b0);
        idle(3);

        // Redirect to a halfword target drops the low half.
        do_flush(32'h102);
        push(32'h0000_4505, 32'h102, 1'b1, 1'b0);
        send(32'h4505_1234, 1'b0);
        idle(3);

        // Backpressure keeps outputs stable and blocks fetch.
        do_flush(32'h80);
        out_ready = 1'b0;
        push(32'h0000_0013, 32'h80, 1'b0, 1'b0);
        send(32'h0000_0013, 1'b0);
        fetch_valid = 1'b1;
        fetch_rdata = 32'h0010_0093;
        push(32'h0010_0093, 32'h84, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'h0, out_valid}, 32'h1);
            check("bp_out_instr", out_instr, 32'h0000_0013);
            check("bp_out_pc", out_pc, 32'h80);
            check("bp_fetch_ready", {31'h0, fetch_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'h0, fetch_ready}, 32'h1);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", {31'h0, out_valid}, 32'h1);
        check("bp_next_pc", out_pc, 32'h84);
        idle(3);

        // Bus error, dropped words, then flush resumes.
        do_flush(32'h90);
        push(32'h0, 32'h90, 1'b0, 1'b1);
        send(32'hdead_beef, 1'b1);
        send(32'h0000_0013, 1'b0);
        send(32'h4505_4501, 1'b0);
        idle(3);
        do_flush(32'h200);
        push(32'h0000_0013, 32'h200, 1'b0, 1'b0);
        send(32'h0000_0013, 1'b0);
        idle(3);

        // Error on a skipped word is reported at the redirect PC.
        do_flush(32'h302);
        push(32'h0, 32'h302, 1'b0, 1'b1);
        send(32'h1234_5678, 1'b1);
        idle(3);

        // PC wrap-around from the top halfword.
        do_flush(32'hffff_fffe);
        push(32'h0000_4505, 32'hffff_fffe, 1'b1, 1'b0);
        send(32'h4505_0001, 1'b0);
        push(32'h0000_0013, 32'h0, 1'b0, 1'b0);
        send(32'h0000_0013, 1'b0);
        idle(3);

        // Reset mid-instruction discards the partial state.
        do_flush(32'h40);
        send(32'h0013_4501, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_out_pc", out_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(32'h0000_0013, 32'h80, 1'b0, 1'b0);
        send(32'h0000_0013, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        idle(2);
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
